imem_stream_loader: RTL and testbench
=====================================

// Module: imem_stream_loader
// PURPOSE
// - Boot-time writer for the pipelined CPU's instruction memory. Takes a byte stream over a
//   valid/ready handshake and packs it little-endian into 32-bit words.
// - Writes each word into imem at consecutive word addresses starting at 0.
// - Holds the CPU in reset until the final word is written, then releases it.
// - Replaces direct hierarchical pokes of imem.memory with a synthesizable load path.
// PARAMETERS
// - IMEM_DEPTH  256  number of 32-bit words in instruction memory
// - ADDR_W      8    imem word-address width; must satisfy 2**ADDR_W >= IMEM_DEPTH
// PORTS
// - clk           in   1        system clock, rising edge
// - reset         in   1        asynchronous, active-low reset
// - in_valid      in   1        byte present on in_data
// - in_data       in   8        stream byte
// - in_last       in   1        qualifies the final byte of the program (valid with in_valid)
// - in_ready      out  1        loader accepts a byte; transfer = in_valid & in_ready
// - restart       in   1        one-cycle pulse; in DONE, begins a new load
// - imem_we       out  1        imem write strobe, one cycle per word
// - imem_addr     out  ADDR_W   imem word address
// - imem_wdata    out  32       imem write data
// - cpu_reset     out  1        active-high reset to cpu_pipelined; 1 = hold CPU
// - load_done     out  1        program fully written, CPU released
// - word_count    out  ADDR_W+1 data words written, terminator excluded
// - overflow_err  out  1        sticky: stream exceeded IMEM_DEPTH words
// BEHAVIOUR
// - All outputs are registered.
// - Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1,
//   load_done=0, word_count=0, overflow_err=0, state=IDLE, byte_idx=0.
// - Reset is asynchronous. Asserting it mid-load discards the partial word and all counters.
// - in_ready rises on the first clk edge after reset deasserts.
// - States:
//   - IDLE: in_ready=1. First transfer -> LOAD, or -> FLUSH if in_last.
//   - LOAD: in_ready=1. Transfer with in_last -> FLUSH, and in_ready=0 from the next cycle.
//   - FLUSH: in_ready=0. Completes the pending partial word, then the optional terminator.
//     Then -> DONE.
//   - DONE: in_ready=0, cpu_reset=0, load_done=1. restart -> IDLE, which sets cpu_reset=1,
//     load_done=0, word_count=0, overflow_err=0, and the address back to 0.
// - Packing: byte k of a word goes to bits [8k+7:8k], k = byte_idx (2-bit, wraps 3 -> 0).
// - Word write: the cycle after the transfer that fills byte 3, imem_we=1 for exactly one cycle.
//   - imem_addr = word index, imem_wdata = assembled word.
//   - word_count increments on the same edge.
// - Throughput: one byte per cycle sustained. A word write never stalls input.
// - Partial word at in_last: unfilled bytes are zero. Written in the first FLUSH cycle.
// - in_last on a byte that completes a word: the normal write occurs and no extra data write
//   is issued.
// - Overflow: when word index == IMEM_DEPTH, further words are not written (no address wrap).
//   Bytes are still accepted and dropped. overflow_err=1, sticky until reset or restart.
// - in_last/in_data are ignored when in_valid=0.
// - restart outside DONE is ignored.
// - load_done and cpu_reset change together on the same edge.
// CONFIGURATION
// - LOADER_TERMINATOR_EN defined:
//   - After the last data word, FLUSH writes 32'h00000000 at the next address, one cycle
//     later. This is the CPU's end_program marker.
//   - Skipped if the address == IMEM_DEPTH.
//   - Not counted in word_count.
// - LOADER_TERMINATOR_EN undefined: no terminator write. FLUSH ends after the data write,
//   which takes 0 or 1 cycles.
// TESTING
// - Bytes 93 00 10 00 13 01 20 00 (last on 8th), EN defined -> mem[0]=00100093,
//   mem[1]=00200113, mem[2]=00000000; word_count=2; load_done=1; cpu_reset=0.
// - Same stream, EN undefined -> only two imem_we pulses; mem[2] untouched.
// - 5 bytes 11 22 33 44 AA (last on 5th) -> mem[0]=44332211, mem[1]=000000AA;
//   word_count=2; in_ready=0 after the 5th byte.
// - Same 8 bytes with random in_valid gaps of 0-3 cycles -> identical imem contents.
//   One imem_we per word, each 1 cycle after the 4th byte.
// - IMEM_DEPTH=4, 20 bytes -> 4 writes at addresses 0..3; overflow_err=1; no write to
//   address 0 again; word_count=4.
// - Assert reset after 6 bytes -> all outputs at reset values immediately. Reload of 4 bytes
//   -> first write at address 0, word_count=1. Then restart in DONE -> cpu_reset=1,
//   load_done=0, in_ready=1 next cycle.

Source files
------------

// File: rtl/imem_stream_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit imem words and holds the CPU in reset until done.
// Optional feature: define LOADER_TERMINATOR_EN to append a zero end_program word after the data.
module imem_stream_loader #(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(IMEM_DEPTH);

  if ((2 ** ADDR_W) < IMEM_DEPTH) begin : g_bad_cfg
    $error("imem_stream_loader: ADDR_W too small for IMEM_DEPTH");
  end

  logic [1:0]        state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       buf_q, buf_d;
  logic              in_ready_q, in_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              load_done_q, load_done_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              overflow_err_q, overflow_err_d;
`ifdef LOADER_TERMINATOR_EN
  logic              term_sent_q, term_sent_d;
`endif

  logic        xfer;
  logic [31:0] word_asm;
  logic        word_end;
  logic        room;

  assign xfer     = in_valid & in_ready_q;
  // Bytes above byte_idx are still zero in buf_q, so a short final word is zero-padded for free.
  assign word_asm = {8'h00, buf_q} | ({24'h000000, in_data} << {byte_idx_q, 3'b000});
  assign word_end = (byte_idx_q == 2'd3) | in_last;
  assign room     = (word_count_q < DEPTH_W);

  always_comb begin
    state_d        = state_q;
    byte_idx_d     = byte_idx_q;
    buf_d          = buf_q;
    in_ready_d     = in_ready_q;
    imem_we_d      = 1'b0;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    cpu_reset_d    = cpu_reset_q;
    load_done_d    = load_done_q;
    word_count_d   = word_count_q;
    overflow_err_d = overflow_err_q;
`ifdef LOADER_TERMINATOR_EN
    term_sent_d    = term_sent_q;
`endif

    case (state_q)
      ST_IDLE, ST_LOAD: begin
        in_ready_d = 1'b1;
        if (xfer) begin
          byte_idx_d = byte_idx_q + 2'd1;
          buf_d      = word_asm[23:0];
          if (word_end) begin
            byte_idx_d = 2'd0;
            buf_d      = '0;
            // Once the memory is full, words are dropped rather than wrapping onto address 0.
            if (room) begin
              imem_we_d    = 1'b1;
              imem_addr_d  = word_count_q[ADDR_W-1:0];
              imem_wdata_d = word_asm;
              word_count_d = word_count_q + 1'b1;
            end else begin
              overflow_err_d = 1'b1;
            end
          end
          if (in_last) begin
            state_d    = ST_FLUSH;
            in_ready_d = 1'b0;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      ST_FLUSH: begin
`ifdef LOADER_TERMINATOR_EN
        if (!term_sent_q) begin
          term_sent_d = 1'b1;
          if (room) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_count_q[ADDR_W-1:0];
            imem_wdata_d = 32'h00000000;
          end
        end else begin
          term_sent_d = 1'b0;
          state_d     = ST_DONE;
          cpu_reset_d = 1'b0;
          load_done_d = 1'b1;
        end
`else
        state_d     = ST_DONE;
        cpu_reset_d = 1'b0;
        load_done_d = 1'b1;
`endif
      end

      ST_DONE: begin
        if (restart) begin
          state_d        = ST_IDLE;
          in_ready_d     = 1'b1;
          cpu_reset_d    = 1'b1;
          load_done_d    = 1'b0;
          word_count_d   = '0;
          overflow_err_d = 1'b0;
          imem_addr_d    = '0;
          byte_idx_d     = 2'd0;
          buf_d          = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      byte_idx_q     <= 2'd0;
      buf_q          <= '0;
      in_ready_q     <= 1'b0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
      cpu_reset_q    <= 1'b1;
      load_done_q    <= 1'b0;
      word_count_q   <= '0;
      overflow_err_q <= 1'b0;
`ifdef LOADER_TERMINATOR_EN
      term_sent_q    <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      byte_idx_q     <= byte_idx_d;
      buf_q          <= buf_d;
      in_ready_q     <= in_ready_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      cpu_reset_q    <= cpu_reset_d;
      load_done_q    <= load_done_d;
      word_count_q   <= word_count_d;
      overflow_err_q <= overflow_err_d;
`ifdef LOADER_TERMINATOR_EN
      term_sent_q    <= term_sent_d;
`endif
    end
  end

  assign in_ready     = in_ready_q;
  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign cpu_reset    = cpu_reset_q;
  assign load_done    = load_done_q;
  assign word_count   = word_count_q;
  assign overflow_err = overflow_err_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Randomised bench for imem_stream_loader against a byte-count reference model; honours LOADER_TERMINATOR_EN.
module tb_imem_stream_loader;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
`ifdef LOADER_TERMINATOR_EN
  localparam bit TERM = 1'b1;
`else
  localparam bit TERM = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_last, in_ready, restart;
  logic [7:0]    in_data;
  logic          imem_we, cpu_reset, load_done, overflow_err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   word_count;

  imem_stream_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .restart(restart), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .load_done(load_done),
    .word_count(word_count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: tracks bytes accepted, words issued and the post-last tail length.
  bit            m_ready, m_we, m_cpu_reset, m_done, m_ovf, xfer;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata, m_word;
  int            m_count, m_nb, m_tail;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_cpu_reset = 1; m_done = 0;
      m_count = 0; m_ovf = 0; m_nb = 0; m_word = '0; m_tail = 0;
    end else begin
      m_we = 0;
      if (m_done) begin
        if (restart) begin
          m_done = 0; m_cpu_reset = 1; m_count = 0; m_ovf = 0; m_addr = '0;
          m_ready = 1; m_nb = 0; m_word = '0;
        end
      end else if (m_tail > 0) begin
        m_tail--;
        if (TERM && m_tail == 1 && m_count < DEPTH) begin
          m_we = 1; m_addr = AW'(m_count); m_wdata = '0;
        end
        if (m_tail == 0) begin m_done = 1; m_cpu_reset = 0; end
      end else begin
        xfer = in_valid && m_ready;
        m_ready = 1;
        if (xfer) begin
          m_word[8*(m_nb%4) +: 8] = in_data;
          m_nb++;
          if (m_nb % 4 == 0 || in_last) begin
            if (m_count < DEPTH) begin
              m_we = 1; m_addr = AW'(m_count); m_wdata = m_word; m_count++;
            end else m_ovf = 1;
            m_word = '0;
          end
          if (in_last) begin m_ready = 0; m_tail = TERM ? 2 : 1; end
        end
      end
    end
  end

  logic [31:0] mem [DEPTH];
  int          mem_id [DEPTH];
  int          load_id = 0;
  int          wr_cnt = 0;
  int          zero_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("in_ready", 32'(in_ready), 32'(m_ready));
        chk("imem_we", 32'(imem_we), 32'(m_we));
        if (m_we) begin
          chk("imem_addr", 32'(imem_addr), 32'(m_addr));
          chk("imem_wdata", imem_wdata, m_wdata);
        end
        chk("cpu_reset", 32'(cpu_reset), 32'(m_cpu_reset));
        chk("load_done", 32'(load_done), 32'(m_done));
        chk("word_count", 32'(word_count), 32'(m_count));
        chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
        if (imem_we) begin
          mem[imem_addr] = imem_wdata;
          mem_id[imem_addr] = load_id;
          wr_cnt++;
          if (imem_addr == '0) zero_cnt++;
        end
      end
    end
  endtask

  function automatic logic [31:0] pack(input bq_t q, input int w);
    logic [31:0] r = '0;
    for (int k = 0; k < 4; k++)
      if (4*w + k < q.size()) r[8*k +: 8] = q[4*w + k];
    return r;
  endfunction

  task automatic send_bytes(input bq_t q, input int gap_max, input bit with_last, input bit rnd_rs);
    for (int i = 0; i < q.size(); i++) begin
      int g, w;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (g) begin
        in_valid = 0; in_data = 8'($urandom); in_last = 1'($urandom);
        restart = rnd_rs && ($urandom_range(3, 0) == 0);
        @(negedge clk);
      end
      restart = 0;
      w = 0;
      while (!in_ready && w < 20) begin in_valid = 0; @(negedge clk); w++; end
      chk("ready_wait", 32'(in_ready), 32'd1);
      in_valid = 1; in_data = q[i]; in_last = with_last && (i == q.size() - 1);
      @(negedge clk);
    end
    in_valid = 0; in_last = 0;
  endtask

  task automatic wait_done();
    int w = 0;
    while (!load_done && w < 50) begin @(negedge clk); w++; end
    chk("done_wait", 32'(load_done), 32'd1);
  endtask

  task automatic do_restart();
    restart = 1; @(negedge clk); restart = 0;
  endtask

  task automatic check_mem(input bq_t q, input int wr0);
    int nw, dw, exp_wr;
    nw = (q.size() + 3) / 4;
    dw = (nw < DEPTH) ? nw : DEPTH;
    exp_wr = dw + ((TERM && nw < DEPTH) ? 1 : 0);
    chk("write_count", 32'(wr_cnt - wr0), 32'(exp_wr));
    chk("final_word_count", 32'(word_count), 32'(dw));
    chk("final_overflow", 32'(overflow_err), 32'(nw > DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      bit wr_exp;
      wr_exp = (i < nw) || (TERM && i == nw);
      chk("mem_written", 32'(mem_id[i] == load_id), 32'(wr_exp));
      if (wr_exp) chk("mem_data", mem[i], (i < nw) ? pack(q, i) : 32'h0);
    end
  endtask

  initial begin
    bq_t qa, qb, qd, qr;
    int  wr0, z0;
    fork compare_loop(); join_none
    rst_n = 0; in_valid = 0; in_data = '0; in_last = 0; restart = 0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_overflow", 32'(overflow_err), 32'd0);
    #2 rst_n = 1;
    @(negedge clk);

    // Two-instruction program, back to back.
    qa = {8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
    load_id++; wr0 = wr_cnt;
    send_bytes(qa, 0, 1, 0);
    wait_done();
    chk("A_mem0", mem[0], 32'h00100093);
    chk("A_mem1", mem[1], 32'h00200113);
    chk("A_count", 32'(word_count), 32'd2);
    chk("A_cpu_reset", 32'(cpu_reset), 32'd0);
`ifdef LOADER_TERMINATOR_EN
    chk("A_term", mem[2], 32'h00000000);
    chk("A_writes", 32'(wr_cnt - wr0), 32'd3);
`else
    chk("A_mem2_untouched", 32'(mem_id[2] == load_id), 32'd0);
    chk("A_writes", 32'(wr_cnt - wr0), 32'd2);
`endif
    check_mem(qa, wr0);

    // Short final word is zero-padded.
    do_restart();
    qb = {8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    load_id++; wr0 = wr_cnt;
    send_bytes(qb, 0, 1, 0);
    wait_done();
    chk("B_mem0", mem[0], 32'h44332211);
    chk("B_mem1", mem[1], 32'h000000AA);
    chk("B_count", 32'(word_count), 32'd2);
    chk("B_in_ready", 32'(in_ready), 32'd0);
    check_mem(qb, wr0);

    // Same program with valid gaps.
    do_restart();
    load_id++; wr0 = wr_cnt;
    send_bytes(qa, 3, 1, 1);
    wait_done();
    chk("C_mem0", mem[0], 32'h00100093);
    chk("C_mem1", mem[1], 32'h00200113);
    check_mem(qa, wr0);

    // Twenty bytes into a four-word memory.
    do_restart();
    qd = {};
    for (int i = 0; i < 20; i++) qd.push_back(8'($urandom));
    load_id++; wr0 = wr_cnt; z0 = zero_cnt;
    send_bytes(qd, 1, 1, 0);
    wait_done();
    chk("D_overflow", 32'(overflow_err), 32'd1);
    chk("D_count", 32'(word_count), 32'd4);
    chk("D_writes", 32'(wr_cnt - wr0), 32'd4);
    chk("D_addr0_writes", 32'(zero_cnt - z0), 32'd1);
    check_mem(qd, wr0);

    for (int it = 0; it < 14; it++) begin
      int len;
      do_restart();
      len = int'($urandom_range(22, 1));
      qr = {};
      for (int i = 0; i < len; i++) qr.push_back(8'($urandom));
      load_id++; wr0 = wr_cnt;
      send_bytes(qr, int'($urandom_range(3, 0)), 1, 1);
      wait_done();
      check_mem(qr, wr0);
    end

    // Reset in the middle of a load, then reload and restart.
    do_restart();
    qr = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    load_id++;
    send_bytes(qr, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("mid_in_ready", 32'(in_ready), 32'd0);
    chk("mid_imem_we", 32'(imem_we), 32'd0);
    chk("mid_imem_addr", 32'(imem_addr), 32'd0);
    chk("mid_imem_wdata", imem_wdata, 32'd0);
    chk("mid_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("mid_load_done", 32'(load_done), 32'd0);
    chk("mid_word_count", 32'(word_count), 32'd0);
    chk("mid_overflow", 32'(overflow_err), 32'd0);
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    qr = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
    load_id++; wr0 = wr_cnt; z0 = zero_cnt;
    send_bytes(qr, 0, 1, 0);
    wait_done();
    chk("R_mem0", mem[0], 32'hDEADBEEF);
    chk("R_count", 32'(word_count), 32'd1);
    chk("R_addr0_writes", 32'(zero_cnt - z0), 32'd1);
    check_mem(qr, wr0);
    do_restart();
    chk("RS_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("RS_load_done", 32'(load_done), 32'd0);
    chk("RS_in_ready", 32'(in_ready), 32'd1);
    chk("RS_word_count", 32'(word_count), 32'd0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
